// File: rtl/fpu_issue_ctrl.sv
// Issue/sequencing control for the multi-cycle FPU: single in-flight op, RAW/WAW interlock, writeback request.
// Optional macro FPU_DIV_EN enables fdiv.s/fsqrt.s; when undefined those ops are rejected with ill_op.
module fpu_issue_ctrl #(
  parameter int unsigned LAT_ADD  = 3,
  parameter int unsigned LAT_MUL  = 4,
  parameter int unsigned LAT_DIV  = 16,
  parameter int unsigned LAT_MISC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid,
  input  logic       dec_is_fp,
  input  logic [4:0] dec_funct5,
  input  logic [4:0] dec_rd,
  input  logic       dec_rd_f,
  input  logic       dec_rd_x,
  input  logic [4:0] dec_rs1,
  input  logic [4:0] dec_rs2,
  input  logic       dec_rs1_f,
  input  logic       dec_rs2_f,
  input  logic       flush,
  input  logic       wb_gnt,
  output logic       stall,
  output logic       fpu_start,
  output logic [4:0] fpu_op,
  output logic       wb_req,
  output logic [4:0] wb_rd,
  output logic       wb_to_int,
  output logic       fpu_busy,
  output logic       ill_op
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [1:0] state;
  logic [7:0] cnt;
  logic       pend_v;
  logic [4:0] pend_rd;
  logic       pend_int;

  logic       is_div;
  logic       to_int_d;
  logic [7:0] lat_m1;
  logic       raw1;
  logic       raw2;
  logic       waw;
  logic       take;
  logic       accept;

  always_comb begin
    is_div   = (dec_funct5 == 5'b00011) || (dec_funct5 == 5'b01011);
    to_int_d = (dec_funct5 == 5'b11000) || (dec_funct5 == 5'b11100) || (dec_funct5 == 5'b10100);
    case (dec_funct5)
      5'b00000, 5'b00001: lat_m1 = 8'(LAT_ADD - 1);
      5'b00010:           lat_m1 = 8'(LAT_MUL - 1);
      5'b00011, 5'b01011: lat_m1 = 8'(LAT_DIV - 1);
      default:            lat_m1 = 8'(LAT_MISC - 1);
    endcase
  end

  // x0 is hardwired, so a pending X-file write to index 0 never creates a hazard.
  always_comb begin
    raw1 = pend_v && (dec_rs1 == pend_rd) && (dec_rs1_f != pend_int) && !(pend_int && (pend_rd == 5'd0));
    raw2 = pend_v && (dec_rs2 == pend_rd) && (dec_rs2_f != pend_int) && !(pend_int && (pend_rd == 5'd0));
    waw  = pend_v && ((dec_rd_x && pend_int) || (dec_rd_f && !pend_int)) && (dec_rd == pend_rd)
           && !(pend_int && (pend_rd == 5'd0));
    stall = dec_valid && !flush && ((dec_is_fp && (state != IDLE)) || raw1 || raw2 || waw);
    take  = dec_valid && dec_is_fp && !flush && !stall;
`ifdef FPU_DIV_EN
    accept = take;
    ill_op = 1'b0;
`else
    accept = take && !is_div;
    ill_op = take && is_div;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_v    <= 1'b0;
      pend_rd   <= '0;
      pend_int  <= 1'b0;
      fpu_start <= 1'b0;
      fpu_op    <= '0;
    end else begin
      fpu_start <= accept;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= EXEC;
            cnt      <= lat_m1;
            fpu_op   <= dec_funct5;
            pend_rd  <= dec_rd;
            pend_int <= to_int_d;
            pend_v   <= 1'b1;
          end
        end
        EXEC: begin
          if (cnt == 8'd0) state <= WB;
          else             cnt   <= cnt - 8'd1;
        end
        WB: begin
          if (wb_gnt) begin
            state  <= IDLE;
            pend_v <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb_req    = (state == WB);
  assign wb_rd     = pend_rd;
  assign wb_to_int = pend_int;
  assign fpu_busy  = (state != IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: cycle-number reference model plus a decoupled writeback monitor.
module tb_fpu_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid, dec_is_fp, dec_rd_f, dec_rd_x, dec_rs1_f, dec_rs2_f, flush, wb_gnt;
  logic [4:0] dec_funct5, dec_rd, dec_rs1, dec_rs2;
  logic       stall, fpu_start, wb_req, wb_to_int, fpu_busy, ill_op;
  logic [4:0] fpu_op, wb_rd;

  fpu_issue_ctrl #(.LAT_ADD(3), .LAT_MUL(4), .LAT_DIV(16), .LAT_MISC(1)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_is_fp(dec_is_fp),
    .dec_funct5(dec_funct5), .dec_rd(dec_rd), .dec_rd_f(dec_rd_f), .dec_rd_x(dec_rd_x),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs1_f(dec_rs1_f), .dec_rs2_f(dec_rs2_f),
    .flush(flush), .wb_gnt(wb_gnt), .stall(stall), .fpu_start(fpu_start), .fpu_op(fpu_op),
    .wb_req(wb_req), .wb_rd(wb_rd), .wb_to_int(wb_to_int), .fpu_busy(fpu_busy), .ill_op(ill_op)
  );

  always #5 clk = ~clk;

`ifdef FPU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [4:0] rd;
    bit         to_int;
    logic [4:0] op;
    int         ready;
  } exp_t;

  exp_t sbq[$];
  int   ncmp = 0;
  int   nbad = 0;
  int   cyc  = 0;
  bit   mon_en = 1'b0;

  // Reference model: the in-flight op and the cycle numbers at which it starts and becomes ready.
  bit         m_v = 1'b0;
  logic [4:0] m_rd = '0;
  bit         m_int = 1'b0;
  logic [4:0] m_op = '0;
  int         m_acc = 0;
  int         m_ready = 0;

  logic [4:0] f5_pool [10] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01011,
                               5'b11000, 5'b11100, 5'b10100, 5'b00100, 5'b00101};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit f_to_int(input logic [4:0] f5);
    return (f5 == 5'b11000) || (f5 == 5'b11100) || (f5 == 5'b10100);
  endfunction

  function automatic bit f_is_div(input logic [4:0] f5);
    return (f5 == 5'b00011) || (f5 == 5'b01011);
  endfunction

  function automatic int f_lat(input logic [4:0] f5);
    if (f5 == 5'b00000 || f5 == 5'b00001) return 3;
    if (f5 == 5'b00010) return 4;
    if (f5_is_div_wrap(f5)) return 16;
    return 1;
  endfunction

  function automatic bit f5_is_div_wrap(input logic [4:0] f5);
    return f_is_div(f5);
  endfunction

  function automatic bit m_reads(input logic [4:0] rs, input bit rsf);
    return m_v && (rs == m_rd) && (rsf != m_int) && !(m_int && rs == 5'd0);
  endfunction

  task automatic step(input bit rst, input bit v, input bit fp, input logic [4:0] f5,
                      input logic [4:0] rd, input bit rdf, input bit rdx,
                      input logic [4:0] rs1, input logic [4:0] rs2, input bit r1f, input bit r2f,
                      input bit fl, input bit gnt);
    bit e_stall, e_take, e_ill, e_acc, e_wb, waw;
    @(posedge clk);
    cyc++;
    #1;
    reset = rst; dec_valid = v; dec_is_fp = fp; dec_funct5 = f5; dec_rd = rd;
    dec_rd_f = rdf; dec_rd_x = rdx; dec_rs1 = rs1; dec_rs2 = rs2;
    dec_rs1_f = r1f; dec_rs2_f = r2f; flush = fl; wb_gnt = gnt;
    @(negedge clk);
    waw     = m_v && ((rdx && m_int) || (rdf && !m_int)) && (rd == m_rd) && !(m_int && rd == 5'd0);
    e_stall = v && !fl && ((fp && m_v) || m_reads(rs1, r1f) || m_reads(rs2, r2f) || waw);
    e_take  = v && fp && !fl && !e_stall;
    e_ill   = e_take && f_is_div(f5) && !DIV_EN;
    e_acc   = e_take && !e_ill;
    e_wb    = m_v && (cyc >= m_ready);
    chk("stall", 32'(stall), 32'(e_stall));
    chk("ill_op", 32'(ill_op), 32'(e_ill));
    chk("fpu_start", 32'(fpu_start), 32'(m_v && cyc == m_acc + 1));
    chk("fpu_busy", 32'(fpu_busy), 32'(m_v));
    chk("wb_req", 32'(wb_req), 32'(e_wb));
    if (m_v) chk("fpu_op", 32'(fpu_op), 32'(m_op));
    #1;
    if (rst) begin
      m_v = 1'b0;
      sbq.delete();
    end else if (e_wb && gnt) begin
      m_v = 1'b0;
    end else if (e_acc) begin
      exp_t e;
      m_v = 1'b1; m_rd = rd; m_int = f_to_int(f5); m_op = f5;
      m_acc = cyc; m_ready = cyc + 1 + f_lat(f5);
      e.rd = rd; e.to_int = m_int; e.op = f5; e.ready = m_ready;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n, input bit gnt);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0, gnt);
  endtask

  // Writeback monitor: pops an expectation on each new wb_req and checks it is held until grant.
  exp_t cur;
  bit   prev_wb = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (wb_req && !prev_wb) begin
        if (sbq.size() == 0) begin
          chk("wb_unexpected", 32'(wb_req), 32'd0);
        end else begin
          cur = sbq.pop_front();
          chk("wb_rd", 32'(wb_rd), 32'(cur.rd));
          chk("wb_to_int", 32'(wb_to_int), 32'(cur.to_int));
          chk("wb_op", 32'(fpu_op), 32'(cur.op));
          chk("wb_cycle", 32'(cyc), 32'(cur.ready));
        end
      end else if (wb_req) begin
        chk("wb_rd_hold", 32'(wb_rd), 32'(cur.rd));
        chk("wb_to_int_hold", 32'(wb_to_int), 32'(cur.to_int));
      end
      prev_wb = wb_req;
    end
  end

  initial begin
    reset = 1'b1; dec_valid = 0; dec_is_fp = 0; dec_funct5 = '0; dec_rd = '0; dec_rd_f = 0;
    dec_rd_x = 0; dec_rs1 = '0; dec_rs2 = '0; dec_rs1_f = 0; dec_rs2_f = 0; flush = 0; wb_gnt = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_start", 32'(fpu_start), 32'd0);
    chk("rst_op", 32'(fpu_op), 32'd0);
    chk("rst_wb_req", 32'(wb_req), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_to_int", 32'(wb_to_int), 32'd0);
    chk("rst_busy", 32'(fpu_busy), 32'd0);
    chk("rst_ill", 32'(ill_op), 32'd0);
    mon_en = 1'b1;

    // fadd.s f3: start one cycle later, wb_req three cycles after start
    step(0, 1, 1, 5'b00000, 5'd3, 1, 0, 5'd1, 5'd2, 1, 1, 0, 0);
    idle(6, 1);
    // fmul.s f5: X-file add passes, fsgnj reading f5 stalls, gnt held off for a while
    step(0, 1, 1, 5'b00010, 5'd5, 1, 0, 5'd1, 5'd2, 1, 1, 0, 0);
    step(0, 1, 0, 5'b00000, 5'd1, 0, 1, 5'd5, 5'd2, 0, 0, 0, 0);
    step(0, 1, 0, 5'b00000, 5'd7, 0, 1, 5'd8, 5'd9, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 1, 5'b00100, 5'd6, 1, 0, 5'd5, 5'd1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 5'b00100, 5'd6, 1, 0, 5'd5, 5'd1, 1, 1, 0, 1);
    idle(2, 1);
    // fcvt.w.s x6 then WAW on x6; then fcvt to x0 with x0 readers
    step(0, 1, 1, 5'b11000, 5'd6, 0, 1, 5'd1, 5'd2, 1, 1, 0, 0);
    step(0, 1, 0, 5'b00000, 5'd6, 0, 1, 5'd0, 5'd0, 0, 0, 0, 0);
    idle(3, 1);
    step(0, 1, 1, 5'b11000, 5'd0, 0, 1, 5'd1, 5'd2, 1, 1, 0, 0);
    step(0, 1, 0, 5'b00000, 5'd0, 0, 1, 5'd0, 5'd0, 0, 0, 0, 0);
    idle(3, 1);
    // fdiv.s: long latency or ill_op depending on build
    step(0, 1, 1, 5'b00011, 5'd2, 1, 0, 5'd1, 5'd3, 1, 1, 0, 0);
    idle(20, 1);
    // reset during EXEC abandons the op
    step(0, 1, 1, 5'b00010, 5'd4, 1, 0, 5'd1, 5'd3, 1, 1, 0, 0);
    idle(2, 0);
    step(1, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0, 0);
    idle(2, 1);
    // flush suppresses an otherwise acceptable op
    step(0, 1, 1, 5'b00000, 5'd9, 1, 0, 5'd1, 5'd3, 1, 1, 1, 0);
    idle(2, 1);

    for (int i = 0; i < 3000; i++) begin
      logic [4:0] f5, rd, rs1, rs2;
      bit fp, rdf, rdx;
      fp  = ($urandom_range(0, 1) == 1);
      f5  = f5_pool[$urandom_range(0, 9)];
      rd  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      if (fp) begin rdx = f_to_int(f5); rdf = !rdx; end
      else begin rdx = ($urandom_range(0, 1) == 1); rdf = !rdx && ($urandom_range(0, 1) == 1); end
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0), fp, f5, rd, rdf, rdx, rs1, rs2,
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1));
    end
    idle(30, 1);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
